// File: rtl/fa_tv_pkg.sv
// Shared constants and types for the full-adder test-vector recorder.
//   VEC_W    : vector width {a, b, cin, s, cout}
//   DEPTH    : number of buffer entries (power of two)
//   TERM_VEC : terminator vector, stored and then ends a recording
package fa_tv_pkg;

    localparam int VEC_W = 5;
    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);

    localparam logic [VEC_W-1:0] TERM_VEC = 5'b11100;

    // Count constants, sized to the count width.
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);

    typedef logic [VEC_W-1:0] tv_vec_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECORD = 2'd1,
        DONE   = 2'd2
    } rec_state_t;

endpackage

// File: rtl/tv_ram.sv
// Simple dual-port RAM: DEPTH x VEC_W storage with one synchronous write
// port and one registered read port. The read register only updates when
// re is high, so the last result holds between reads. Read-before-write
// semantics on a same-address collision.
//   clk   : clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   re    : read enable
//   raddr : read address
//   rdata : registered read data
module tv_ram
    import fa_tv_pkg::*;
(
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  tv_vec_t       wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output tv_vec_t       rdata
);

    tv_vec_t mem_r [DEPTH];
    tv_vec_t rdata_r;

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata_r <= mem_r[raddr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/fa_vector_recorder.sv
// Writer side of the full-adder test-vector flow. Captures observed
// {a, b, cin, s, cout} vectors into a buffer until the terminator vector
// or a full buffer, then exposes the table through a registered read port.
//   clk      : clock, rising edge
//   reset    : synchronous active-low reset
//   start    : begin a new recording (honoured in IDLE or DONE)
//   in_valid : in_vec valid this cycle
//   in_vec   : observed vector
//   in_ready : recorder accepts a vector this cycle (RECORD)
//   rd_en    : read request
//   rd_addr  : read address
//   rd_data  : read result, one cycle after rd_en; 0 for addr >= count
//   rd_valid : rd_data valid, one cycle after rd_en
//   busy     : recording in progress
//   done     : recording finished
//   count    : entries written, terminator included
//   overflow : buffer filled without a terminator
module fa_vector_recorder
    import fa_tv_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          in_valid,
    input  tv_vec_t       in_vec,
    output logic          in_ready,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output tv_vec_t       rd_data,
    output logic          rd_valid,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] count,
    output logic          overflow
);

    rec_state_t    state_r;
    rec_state_t    state_nxt_s;
    logic [CW-1:0] count_r;
    logic          overflow_r;
    logic          rd_valid_r;
    logic          in_range_r;
    tv_vec_t       ram_q_s;

    logic          recording_s;
    logic          accept_s;
    logic          is_term_s;
    logic          at_last_s;
    logic          restart_s;

    assign recording_s = (state_r == RECORD);
    assign accept_s    = in_valid & recording_s;
    assign is_term_s   = (in_vec == TERM_VEC);
    assign at_last_s   = (count_r == CNT_LAST);
    // start is only honoured outside RECORD.
    assign restart_s   = start & ~recording_s;

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = RECORD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RECORD: begin
                if (accept_s && (is_term_s || at_last_s)) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RECORD;
                end
            end
            DONE: begin
                if (start) begin
                    state_nxt_s = RECORD;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, entry count and overflow flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r    <= IDLE;
            count_r    <= CNT_ZERO;
            overflow_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (restart_s) begin
                count_r    <= CNT_ZERO;
                overflow_r <= 1'b0;
            end else if (accept_s) begin
                // The last slot taken by a non-terminator means the
                // recording ran out of room.
                count_r <= count_r + CNT_ONE;
                if (at_last_s && !is_term_s) begin
                    overflow_r <= 1'b1;
                end
            end
        end
    end

    // The write slot is always the current count, so a concurrent read
    // (which must be below count) never targets it.
    tv_ram u_ram (
        .clk   (clk),
        .we    (accept_s),
        .waddr (count_r[AW-1:0]),
        .wdata (in_vec),
        .re    (rd_en),
        .raddr (rd_addr),
        .rdata (ram_q_s)
    );

    // Read handshake and range qualifier, both judged on the pre-edge count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_valid_r <= 1'b0;
            in_range_r <= 1'b0;
        end else begin
            rd_valid_r <= rd_en;
            if (rd_en) begin
                in_range_r <= ({1'b0, rd_addr} < count_r);
            end
        end
    end

    // Both operands are registers that only move on a read, so rd_data
    // holds its last value between reads and is 0 straight after reset.
    assign rd_data  = in_range_r ? ram_q_s : 5'b00000;
    assign rd_valid = rd_valid_r;
    assign in_ready = recording_s;
    assign busy     = recording_s;
    assign done     = (state_r == DONE);
    assign count    = count_r;
    assign overflow = overflow_r;

endmodule

// File: tb/tb_fa_vector_recorder.sv
// Self-checking bench for fa_vector_recorder: directed scenarios plus a
// randomized phase, all checked every cycle against a behavioural model.
module tb_fa_vector_recorder;
    import fa_tv_pkg::*;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    tv_vec_t       in_vec = 5'b00000;
    logic          in_ready;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    tv_vec_t       rd_data;
    logic          rd_valid;
    logic          busy;
    logic          done;
    logic [CW-1:0] count;
    logic          overflow;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    fa_vector_recorder dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in_valid (in_valid),
        .in_vec   (in_vec),
        .in_ready (in_ready),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .busy     (busy),
        .done     (done),
        .count    (count),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Mode: 0 idle, 1 recording, 2 finished.
    int      m_mode  = 0;
    int      m_count = 0;
    bit      m_ovf   = 1'b0;
    bit      m_rv    = 1'b0;
    int      m_rd    = 0;
    int      m_mem [DEPTH];

    task automatic model_step();
        int old_count;
        old_count = m_count;
        if (!reset) begin
            m_mode = 0; m_count = 0; m_ovf = 1'b0; m_rv = 1'b0; m_rd = 0;
        end else begin
            if (rd_en) begin
                m_rv = 1'b1;
                m_rd = (int'(rd_addr) < old_count) ? m_mem[rd_addr] : 0;
            end else begin
                m_rv = 1'b0;
            end
            if (m_mode == 1) begin
                if (in_valid) begin
                    m_mem[m_count] = int'(in_vec);
                    m_count = m_count + 1;
                    if (in_vec == TERM_VEC) m_mode = 2;
                    else if (m_count == DEPTH) begin
                        m_ovf = 1'b1; m_mode = 2;
                    end
                end
            end else if (start) begin
                m_mode = 1; m_count = 0; m_ovf = 1'b0;
            end
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // One clock: DUT and model both see the current inputs at the edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (check_en) begin
            check("in_ready", int'(in_ready), int'(m_mode == 1));
            check("busy",     int'(busy),     int'(m_mode == 1));
            check("done",     int'(done),     int'(m_mode == 2));
            check("count",    int'(count),    m_count);
            check("overflow", int'(overflow), int'(m_ovf));
            check("rd_valid", int'(rd_valid), int'(m_rv));
            check("rd_data",  int'(rd_data),  m_rd);
        end
    end

    task automatic push(input tv_vec_t v);
        in_valid = 1'b1; in_vec = v; tick();
        in_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic read_chk(input int a, input int exp, input string name);
        rd_en = 1'b1; rd_addr = AW'(a); tick(); rd_en = 1'b0;
        check({name, "_valid"}, int'(rd_valid), 1);
        check(name, int'(rd_data), exp);
    endtask

    tv_vec_t tt [9] = '{5'b00000, 5'b00110, 5'b01010, 5'b01101, 5'b10010,
                        5'b10101, 5'b11001, 5'b11111, 5'b11100};

    initial begin
        tick(); tick();
        reset = 1'b1;
        check_en = 1'b1;
        check("rst_count", int'(count), 0);
        check("rst_done",  int'(done), 0);
        check("rst_rdata", int'(rd_data), 0);

        // Idle rejection.
        in_valid = 1'b1; in_vec = 5'b01010;
        repeat (4) tick();
        in_valid = 1'b0;
        check("idle_count", int'(count), 0);
        check("idle_busy",  int'(busy), 0);
        check("idle_ready", int'(in_ready), 0);
        read_chk(0, 0, "idle_rd0");

        // Full truth table.
        do_start();
        for (int i = 0; i < 9; i++) push(tt[i]);
        check("tt_done",  int'(done), 1);
        check("tt_count", int'(count), 9);
        check("tt_model_count", m_count, 9);
        check("tt_ovf",   int'(overflow), 0);
        for (int i = 0; i < 9; i++) read_chk(i, int'(tt[i]), "tt_rd");
        read_chk(9, 0, "tt_rd9");

        // Restart from DONE.
        do_start();
        push(5'b10101); push(5'b11100);
        check("rs_count", int'(count), 2);
        read_chk(0, 21, "rs_rd0");
        read_chk(1, 28, "rs_rd1");
        read_chk(2, 0,  "rs_rd2");

        // Overflow.
        do_start();
        for (int i = 0; i < DEPTH; i++) push(5'b00000);
        check("ov_count", int'(count), 16);
        check("ov_flag",  int'(overflow), 1);
        check("ov_done",  int'(done), 1);
        check("ov_ready", int'(in_ready), 0);
        push(5'b00001);
        check("ov_17th", int'(count), 16);
        read_chk(15, 0, "ov_rd15");

        // Reset mid-record.
        do_start();
        push(5'b00110); push(5'b01010); push(5'b01101);
        rd_en = 1'b1; rd_addr = 4'd0;
        reset = 1'b0; tick(); reset = 1'b1; rd_en = 1'b0;
        check("mr_count", int'(count), 0);
        check("mr_done",  int'(done), 0);
        check("mr_busy",  int'(busy), 0);
        check("mr_rv",    int'(rd_valid), 0);
        do_start();
        push(5'b11100);
        check("mr_count1", int'(count), 1);
        read_chk(0, 28, "mr_rd0");

        // Gapped input with a concurrent read of slot 0 every cycle.
        do_start();
        rd_en = 1'b1; rd_addr = 4'd0;
        for (int i = 0; i < 12; i++) begin
            in_valid = (i % 2 == 1);
            do in_vec = tv_vec_t'($urandom); while (in_vec == TERM_VEC);
            tick();
        end
        in_valid = 1'b0; rd_en = 1'b0;
        tick();
        check("gap_count", int'(count), 6);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            reset    = ($urandom_range(0, 99) != 0);
            start    = ($urandom_range(0, 9) == 0);
            in_valid = $urandom_range(0, 1) == 1;
            in_vec   = ($urandom_range(0, 11) == 0) ? TERM_VEC : tv_vec_t'($urandom);
            rd_en    = $urandom_range(0, 2) != 0;
            rd_addr  = AW'($urandom);
            tick();
        end
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; rd_en = 1'b0;
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
